// File: rtl/alu_execute_unit.sv
// ALU execute unit: AND/OR/ADD/SUB/SLT/XOR/SLL complete in one cycle, MUL is a
// 24-iteration (WIDTH-iteration) unsigned shift-add with the result landing at edge k+WIDTH.
// Backpressure: Start is accepted only in IDLE; Start while Busy=1 is dropped silently.
//
// Ports:
//   Clock, Reset (sync, active-low)     - clock and reset
//   Start, ALUContr[3:0], A, B          - operation request, opcode and operands
//   Result, Zero, Overflow, IllegalOp   - registered result and flags, held between Done pulses
//   Busy                                - high while a multiply is iterating
//   Done                                - one-cycle pulse when Result/flags are reloaded
module alu_execute_unit #(
  parameter int WIDTH = 24
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Start,
  input  logic [3:0]       ALUContr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow,
  output logic             IllegalOp,
  output logic             Busy,
  output logic             Done
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b1010;
  localparam logic [3:0] OP_SLT = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0101;
  localparam logic [3:0] OP_SLL = 4'b0110;
  localparam logic [3:0] OP_MUL = 4'b0100;

  localparam int          CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   ovf_q, ovf_d;
  logic                   ill_q, ill_d;
  logic                   done_q, done_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic [2*WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]       mplier_q, mplier_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [WIDTH-1:0]       sum, diff, alu_res;
  logic                   alu_ovf, alu_ill;
  logic [2*WIDTH-1:0]     acc_sum;

  assign sum  = A + B;
  assign diff = A - B;

  // Single-cycle datapath. MUL produces nothing here; it is handled by the FSM.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    case (ALUContr)
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_ADD: begin
        alu_res = sum;
        // Same-sign operands whose sum flips sign.
        alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        // Opposite-sign operands whose difference takes the sign of B.
        alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: alu_res = (int'(B[4:0]) >= WIDTH) ? '0 : (A << B[4:0]);
      OP_MUL: alu_res = '0;
      default: alu_ill = 1'b1;
    endcase
  end

  // One shift-add step: multiplicand walks left, multiplier walks right.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    done_d   = 1'b0;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;

    if (state_q == S_IDLE) begin
      if (Start) begin
        if (ALUContr == OP_MUL) begin
          // Operands are latched so later input changes cannot disturb the product.
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else begin
          result_d = alu_res;
          zero_d   = (alu_res == '0);
          ovf_d    = alu_ovf;
          ill_d    = alu_ill;
          done_d   = 1'b1;
        end
      end
    end else begin
      acc_d    = acc_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        result_d = acc_sum[WIDTH-1:0];
        zero_d   = (acc_sum[WIDTH-1:0] == '0);
        ovf_d    = |acc_sum[2*WIDTH-1:WIDTH];
        ill_d    = 1'b0;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      done_q   <= 1'b0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
      done_q   <= done_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Result    = result_q;
  assign Zero      = zero_q;
  assign Overflow  = ovf_q;
  assign IllegalOp = ill_q;
  assign Busy      = (state_q == S_MUL);
  assign Done      = done_q;

endmodule

// File: tb/tb_alu_execute_unit.sv
module tb_alu_execute_unit;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [3:0]  ALUContr;
  logic [23:0] A, B;
  logic [23:0] Result;
  logic        Zero, Overflow, IllegalOp, Busy, Done;

  int nchecks = 0;
  int nerrors = 0;

  alu_execute_unit #(.WIDTH(24)) dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .ALUContr(ALUContr),
    .A(A), .B(B), .Result(Result), .Zero(Zero), .Overflow(Overflow),
    .IllegalOp(IllegalOp), .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one request for exactly one edge; returns #1 after that edge.
  task automatic op(input logic [3:0] c, input logic [23:0] a, input logic [23:0] b);
    ALUContr = c; A = a; B = b; Start = 1'b1;
    @(posedge Clock); #1;
    Start = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [23:0] r, input logic z,
                            input logic o, input logic il);
    chk({tag, "/res"},  Result,    r);
    chk({tag, "/zero"}, Zero,      z);
    chk({tag, "/ovf"},  Overflow,  o);
    chk({tag, "/ill"},  IllegalOp, il);
    chk({tag, "/done"}, Done,      1'b1);
    chk({tag, "/busy"}, Busy,      1'b0);
  endtask

  // Starts a MUL and waits (bounded) for Done; optionally fires an ignored AND
  // request and scrambles the operands 5 cycles in. Returns #1 after the Done edge.
  task automatic run_mul(input string tag, input logic [23:0] a, input logic [23:0] b,
                         input bit inject, output int cycles);
    bit busy_bad;
    busy_bad = 1'b0;
    op(4'b0100, a, b);
    chk({tag, "/busy_at_k"}, Busy, 1'b1);
    chk({tag, "/nodone_at_k"}, Done, 1'b0);
    cycles = 1;
    @(posedge Clock); #1;
    while (Done !== 1'b1 && cycles < 40) begin
      if (Busy !== 1'b1) busy_bad = 1'b1;
      if (inject && cycles == 5) begin
        ALUContr = 4'b0000; A = 24'hFFFFFF; B = 24'hFFFFFF; Start = 1'b1;
      end
      @(posedge Clock); #1;
      Start = 1'b0;
      cycles++;
    end
    chk({tag, "/latency"}, cycles, 24);
    chk({tag, "/busy_held"}, busy_bad, 1'b0);
  endtask

  initial begin
    int cyc;
    int dcount;
    Reset = 1'b0; Start = 1'b0; ALUContr = 4'b0; A = '0; B = '0;
    repeat (3) @(posedge Clock);
    #1;
    chk("rst/res", Result, 24'h0);
    chk("rst/flags", {Zero, Overflow, IllegalOp, Busy, Done}, 5'b0);
    Reset = 1'b1;
    @(posedge Clock); #1;

    op(4'b0010, 24'h7FFFFF, 24'h000001); expect_out("add_ovf", 24'h800000, 0, 1, 0);
    @(posedge Clock); #1;
    chk("add_ovf/done_drop", Done, 1'b0);
    chk("add_ovf/hold", Result, 24'h800000);

    op(4'b0010, 24'hFFFFFF, 24'h000001); expect_out("add_wrap", 24'h000000, 1, 0, 0);
    op(4'b1010, 24'h123456, 24'h123456); expect_out("sub_zero", 24'h000000, 1, 0, 0);
    op(4'b1010, 24'h800000, 24'h000001); expect_out("sub_ovf",  24'h7FFFFF, 0, 1, 0);
    op(4'b0000, 24'hF0F0F0, 24'hFF00FF); expect_out("and",      24'hF000F0, 0, 0, 0);
    op(4'b0001, 24'hF0F0F0, 24'h0F0000); expect_out("or",       24'hFFF0F0, 0, 0, 0);
    op(4'b0101, 24'hAAAAAA, 24'hFFFFFF); expect_out("xor",      24'h555555, 0, 0, 0);
    op(4'b0011, 24'hFFFFFF, 24'h000001); expect_out("slt_neg",  24'h000001, 0, 0, 0);
    op(4'b0011, 24'h000001, 24'hFFFFFF); expect_out("slt_pos",  24'h000000, 1, 0, 0);
    op(4'b0110, 24'h000123, 24'h000004); expect_out("sll4",     24'h001230, 0, 0, 0);
    op(4'b0110, 24'h000123, 24'h000018); expect_out("sll24",    24'h000000, 1, 0, 0);
    op(4'b1111, 24'h123456, 24'h654321); expect_out("illegal",  24'h000000, 1, 0, 1);
    op(4'b0010, 24'h000001, 24'h000002); expect_out("after_ill", 24'h000003, 0, 0, 0);

    run_mul("mul_big", 24'h001000, 24'h001000, 1'b0, cyc);
    expect_out("mul_big", 24'h000000, 1, 1, 0);
    run_mul("mul_3x5", 24'h000003, 24'h000005, 1'b0, cyc);
    expect_out("mul_3x5", 24'h00000F, 0, 0, 0);

    run_mul("mul_inj", 24'h000123, 24'h000010, 1'b1, cyc);
    expect_out("mul_inj", 24'h001230, 0, 0, 0);
    // Back-to-back request issued in the Done cycle.
    op(4'b0000, 24'hF0F0F0, 24'hFF00FF); expect_out("b2b_and", 24'hF000F0, 0, 0, 0);

    // Reset 10 cycles into a multiply.
    op(4'b0100, 24'h000007, 24'h000009);
    repeat (9) @(posedge Clock);
    #1;
    chk("mulrst/busy_before", Busy, 1'b1);
    Reset = 1'b0;
    @(posedge Clock); #1;
    Reset = 1'b1;
    chk("mulrst/res", Result, 24'h0);
    chk("mulrst/flags", {Zero, Overflow, IllegalOp, Busy, Done}, 5'b0);
    dcount = 0;
    repeat (30) begin
      @(posedge Clock); #1;
      if (Done === 1'b1) dcount++;
    end
    chk("mulrst/no_done", dcount, 0);

    // Reset wins over a simultaneous Start.
    Reset = 1'b0;
    op(4'b0010, 24'h000002, 24'h000003);
    Reset = 1'b1;
    chk("rst_prio/done", Done, 1'b0);
    chk("rst_prio/res", Result, 24'h0);

    op(4'b0010, 24'h000002, 24'h000003); expect_out("post_rst", 24'h000005, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
